// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the control-unit decoder.
package alu_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/alu_muldiv_seq_md_iter_step.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply or
// restoring divide, selected by mode_i.
module md_iter_step
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mode_e            mode_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum   = acc_i + {1'b0, (shreg_i[0] ? opnd_i : {WIDTH{1'b0}})};
    trial = {acc_i[WIDTH-1:0], shreg_i[WIDTH-1]};
    diff  = trial - {1'b0, opnd_i};
    ge    = (trial >= {1'b0, opnd_i});
    if (mode_i == MODE_DIV) begin
      // Remainder in acc, dividend bits shift out of shreg as quotient bits shift in.
      acc_o   = ge ? diff : trial;
      shreg_o = {shreg_i[WIDTH-2:0], ge};
    end else begin
      acc_o   = {1'b0, sum[WIDTH:1]};
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// FSM IDLE -> PREP -> CALC (WIDTH steps) -> FIX; flush aborts without touching HI/LO.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  mode_e              mode_q, mode_d;
  logic               sgn_q, sgn_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH:0]     acc_step;
  logic [WIDTH-1:0]   shreg_step;
  logic [2*WIDTH-1:0] prod;
  logic               accept;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode_i  (mode_q),
    .acc_i   (acc_q),
    .shreg_i (shreg_q),
    .opnd_i  (opnd_q),
    .acc_o   (acc_step),
    .shreg_o (shreg_step)
  );

  assign in_ready = (state_q == S_IDLE) & ~flush;
  assign accept   = in_valid & in_ready;
  assign prod     = {acc_q[WIDTH-1:0], shreg_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mode_d  = mode_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dz_d = 1'b0;
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = S_PREP;
              shreg_d = a;
              opnd_d  = b;
              mode_d  = op[1] ? MODE_DIV : MODE_MUL;
              sgn_d   = ~op[0];
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_PREP: begin
        acc_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        qneg_d  = sgn_q & (shreg_q[WIDTH-1] ^ opnd_q[WIDTH-1]);
        rneg_d  = sgn_q & shreg_q[WIDTH-1];
        bzero_d = (opnd_q == '0);
        if (sgn_q & shreg_q[WIDTH-1]) shreg_d = -shreg_q;
        if (sgn_q & opnd_q[WIDTH-1])  opnd_d  = -opnd_q;
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d   = acc_step;
        shreg_d = shreg_step;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (mode_q == MODE_MUL) begin
          {hi_d, lo_d} = qneg_q ? -prod : prod;
        end else begin
          // A zero divisor leaves |a| in the remainder, so the sign fix restores a.
          lo_d = bzero_q ? '1 : (qneg_q ? -shreg_q : shreg_q);
          hi_d = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          dz_d = bzero_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      shreg_q <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mode_q  <= MODE_MUL;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mode_q  <= mode_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed checks for alu_muldiv_seq: result vectors, flush, back-to-back and reset.
module tb_alu_muldiv_seq;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one op and returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '1; b = '1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic seen;
    logic [W-1:0] hi_keep, lo_keep;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[8]  = '{3'd3, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'd5, 32'h00000055, 32'd9,        32'hFFFFFFF9, 32'h00000055, 1'b0};
    vecs[11] = '{3'd4, 32'h000000A5, 32'd9,        32'h000000A5, 32'h00000055, 1'b0};
    vecs[12] = '{3'd7, 32'h12345678, 32'd9,        32'h000000A5, 32'h00000055, 1'b0};

    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].op < 3'd4) begin
        check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
        wait_done(lat);
        check($sformatf("v%0d_lat", i), 64'(lat), 64'(LAT));
        check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
        check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
        check($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      end else begin
        check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
        check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
        check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
        check($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
        seen = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          if (done) seen = 1'b1;
        end
        check($sformatf("v%0d_no_done", i), 64'(seen), 64'd0);
      end
    end

    // Flush at T+10 with a competing MTLO on in_valid.
    hi_keep = 32'h000000A5; lo_keep = 32'h00000055;
    issue(3'd0, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi", 64'(hi), 64'(hi_keep));
    check("flush_lo", 64'(lo), 64'(lo_keep));

    // Back-to-back: second op offered in the done cycle of the first.
    issue(3'd1, 32'd3, 32'd5);
    wait_done(lat);
    check("b2b_lat1", 64'(lat), 64'(LAT));
    check("b2b_lo1", 64'(lo), 64'd15);
    check("b2b_ready_at_done", 64'(in_ready), 64'd1);
    @(negedge clk);
    op = 3'd3; a = 32'd15; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_accepted", 64'(busy), 64'd1);
    wait_done(lat);
    check("b2b_lat2", 64'(lat), 64'(LAT));
    check("b2b_lo2", 64'(lo), 64'd3);
    check("b2b_hi2", 64'(hi), 64'd3);

    // Asynchronous reset in the middle of a DIV.
    issue(3'd2, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    issue(3'd4, 32'hA5A5A5A5, 32'd0);
    check("post_rst_hi", 64'(hi), 64'h00000000A5A5A5A5);
    check("post_rst_lo", 64'(lo), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
